// File: rtl/exec_unit.sv
// exec_unit: small execute stage with register-file writeback.
// Single-cycle ALU ops (ADD/SUB/AND/OR/XOR/SHL/MOVB) write back one cycle
// after acceptance. Op 110 is an 8-iteration shift-add multiplier when
// the macro EXEC_MUL_EN is defined. Without it, op 110 occupies the unit
// for one cycle and performs no write.
module exec_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [2:0] dst,
  output logic       busy,
  output logic       wb_we,
  output logic [2:0] wb_addr,
  output logic [7:0] wb_data,
  output logic       zf,
  output logic       cf
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SHL  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_MOVB = 3'b111;

`ifdef EXEC_MUL_EN
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, WB = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, WB = 2'd2} state_t;
`endif

  state_t     state;
  logic [7:0] alu_res;
  logic       alu_cf;

`ifdef EXEC_MUL_EN
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic [2:0]  mul_dst;
  logic [2:0]  mul_cnt;
  logic [15:0] mul_acc;
  logic [15:0] acc_sum;

  // One shift-add step: add a<<cnt when multiplier bit cnt is set.
  always_comb begin
    acc_sum = mul_acc;
    if (mul_b[mul_cnt]) begin
      acc_sum = mul_acc + ({8'h00, mul_a} << mul_cnt);
    end
  end
`endif

  // Single-cycle ALU working directly on the live operands; its result is
  // captured in the same edge that accepts the request.
  always_comb begin
    alu_res = 8'h00;
    alu_cf  = 1'b0;
    case (op)
      OP_ADD:  {alu_cf, alu_res} = {1'b0, a} + {1'b0, b};
      OP_SUB: begin
        alu_res = a - b;
        alu_cf  = (a < b);
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SHL: begin
        alu_res = {a[6:0], 1'b0};
        alu_cf  = a[7];
      end
      OP_MOVB: alu_res = b;
      default: begin
        alu_res = 8'h00;
        alu_cf  = 1'b0;
      end
    endcase
  end

  // Control FSM with all outputs registered; flags only change on WB entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      wb_we   <= 1'b0;
      wb_addr <= 3'd0;
      wb_data <= 8'h00;
      zf      <= 1'b0;
      cf      <= 1'b0;
`ifdef EXEC_MUL_EN
      mul_a   <= 8'h00;
      mul_b   <= 8'h00;
      mul_dst <= 3'd0;
      mul_cnt <= 3'd0;
      mul_acc <= 16'h0000;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (op == OP_MUL) begin
`ifdef EXEC_MUL_EN
              mul_a   <= a;
              mul_b   <= b;
              mul_dst <= dst;
              mul_cnt <= 3'd0;
              mul_acc <= 16'h0000;
              state   <= MUL;
`else
              // No multiplier: occupy the unit for one cycle, write nothing.
              state   <= WB;
`endif
            end else begin
              wb_we   <= 1'b1;
              wb_addr <= dst;
              wb_data <= alu_res;
              zf      <= (alu_res == 8'h00);
              cf      <= alu_cf;
              state   <= WB;
            end
          end
        end
`ifdef EXEC_MUL_EN
        MUL: begin
          mul_acc <= acc_sum;
          mul_cnt <= mul_cnt + 3'd1;
          if (mul_cnt == 3'd7) begin
            wb_we   <= 1'b1;
            wb_addr <= mul_dst;
            wb_data <= acc_sum[7:0];
            zf      <= (acc_sum[7:0] == 8'h00);
            cf      <= (acc_sum[15:8] != 8'h00);
            state   <= WB;
          end
        end
`endif
        WB: begin
          wb_we <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          wb_we <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit: directed vectors for exec_unit with a write-back scoreboard.
// Build with +define+EXEC_MUL_EN to exercise the multiplier path.
module tb_exec_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] dst;
  logic       busy;
  logic       wb_we;
  logic [2:0] wb_addr;
  logic [7:0] wb_data;
  logic       zf;
  logic       cf;

  typedef struct packed {
    logic [2:0] addr;
    logic [7:0] data;
    logic       zf;
    logic       cf;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   writes = 0;

  exec_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .dst(dst), .busy(busy), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_data(wb_data), .zf(zf), .cf(cf)
  );

  always #5 clk = ~clk;

  // Monitor: every write pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (reset === 1'b0 && wb_we === 1'b1) begin
      writes++;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write actual addr=%0d data=%02h zf=%0b cf=%0b required none",
                 wb_addr, wb_data, zf, cf);
      end else begin
        mon_e = q.pop_front();
        if ({wb_addr, wb_data, zf, cf} !== mon_e) begin
          errors++;
          $display("FAIL write actual addr=%0d data=%02h zf=%0b cf=%0b required addr=%0d data=%02h zf=%0b cf=%0b",
                   wb_addr, wb_data, zf, cf, mon_e.addr, mon_e.data, mon_e.zf, mon_e.cf);
        end else begin
          $display("write addr=%0d data=%02h zf=%0b cf=%0b ok", wb_addr, wb_data, zf, cf);
        end
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end else begin
      $display("check %s = %0h ok", name, act);
    end
  endtask

  // Issue one op; optionally queue its expected write and count busy cycles.
  // With noise set, start is pulsed and operands scrambled while busy.
  task automatic run_op(input string name, input logic [2:0] o, input logic [7:0] xa,
                        input logic [7:0] xb, input logic [2:0] xd, input bit wr,
                        input logic [7:0] ed, input logic ez, input logic ec,
                        input int eb, input bit noise);
    exp_t e;
    int   cyc;
    @(negedge clk);
    if (wr) begin
      e.addr = xd; e.data = ed; e.zf = ez; e.cf = ec;
      q.push_back(e);
    end
    start = 1'b1; op = o; a = xa; b = xb; dst = xd;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 40) begin
      cyc++;
      if (noise) begin
        start = 1'b1;
        op = 3'($urandom);
        a = 8'($urandom);
        b = 8'($urandom);
        dst = 3'($urandom);
      end
      @(negedge clk);
      start = 1'b0;
    end
    check({name, "_busy_cycles"}, 16'(cyc), 16'(eb));
  endtask

  initial begin
    int w0;
    reset = 1'b1; start = 1'b0; op = 3'd0; a = 8'h00; b = 8'h00; dst = 3'd0;
    @(negedge clk);
    check("reset_outputs", {3'd0, busy, wb_we, wb_addr, wb_data, zf, cf}, 16'h0000);
    @(negedge clk);
    reset = 1'b0;

    run_op("add_carry", 3'b000, 8'hF0, 8'h20, 3'd3, 1, 8'h10, 0, 1, 1, 0);
    run_op("sub_zero",  3'b001, 8'h05, 8'h05, 3'd1, 1, 8'h00, 1, 0, 1, 0);
    run_op("sub_borrow",3'b001, 8'h03, 8'h04, 3'd2, 1, 8'hFF, 0, 1, 1, 0);
    run_op("and_noise", 3'b010, 8'hF0, 8'h3C, 3'd4, 1, 8'h30, 0, 0, 1, 1);
    run_op("or",        3'b011, 8'h0F, 8'hA0, 3'd6, 1, 8'hAF, 0, 0, 1, 0);
    run_op("xor",       3'b100, 8'h55, 8'h0F, 3'd0, 1, 8'h5A, 0, 0, 1, 0);
    run_op("shl",       3'b101, 8'h40, 8'h99, 3'd5, 1, 8'h80, 0, 0, 1, 0);
    run_op("movb_r7",   3'b111, 8'hFF, 8'h5A, 3'd7, 1, 8'h5A, 0, 0, 1, 0);
    run_op("add_wrap",  3'b000, 8'hFF, 8'h01, 3'd4, 1, 8'h00, 1, 1, 1, 0);

`ifdef EXEC_MUL_EN
    run_op("mul_12x34", 3'b110, 8'h12, 8'h34, 3'd5, 1, 8'hA8, 0, 1, 9, 1);
    run_op("mul_10x10", 3'b110, 8'h10, 8'h10, 3'd1, 1, 8'h00, 1, 1, 9, 0);
    run_op("mul_0fx03", 3'b110, 8'h0F, 8'h03, 3'd2, 1, 8'h2D, 0, 0, 9, 0);
`else
    w0 = writes;
    run_op("op110_nowrite", 3'b110, 8'h12, 8'h34, 3'd5, 0, 8'h00, 0, 0, 1, 0);
    check("op110_write_count", 16'(writes - w0), 16'd0);
    check("op110_hold", {3'd0, wb_addr, wb_data, zf, cf}, {3'd0, 3'd4, 8'h00, 1'b1, 1'b1});
`endif

    // Back-to-back: start held high for six cycles gives three SHL writes.
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      mon_e.addr = 3'd7; mon_e.data = 8'h02; mon_e.zf = 1'b0; mon_e.cf = 1'b1;
      q.push_back(mon_e);
    end
    w0 = writes;
    start = 1'b1; op = 3'b101; a = 8'h81; b = 8'h00; dst = 3'd7;
    repeat (6) @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("b2b_write_count", 16'(writes - w0), 16'd3);

`ifdef EXEC_MUL_EN
    // Reset in the 4th MUL cycle: no write may follow.
    @(negedge clk);
    start = 1'b1; op = 3'b110; a = 8'h12; b = 8'h34; dst = 3'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    w0 = writes;
    check("mul_busy_before_abort", {15'd0, busy}, 16'd1);
`else
    @(negedge clk);
    w0 = writes;
`endif
    reset = 1'b1;
    #1;
    check("async_reset_outputs", {3'd0, busy, wb_we, wb_addr, wb_data, zf, cf}, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_no_write", 16'(writes - w0), 16'd0);

    run_op("xor_after_reset", 3'b100, 8'hAA, 8'hAA, 3'd3, 1, 8'h00, 1, 0, 1, 0);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 16'(q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/exec_unit.md
EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 clk  input  1  single system clock; all state changes on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 start  input  1  request to execute one operation; sampled only in IDLE.
REQ-004 op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL (a<<1), 110 MUL (low byte of a*b), 111 MOVB (pass b).
REQ-005 a  input  8  operand A, driven from register-file read port 1.
REQ-006 b  input  8  operand B, driven from register-file read port 2.
REQ-007 dst  input  3  destination register index.
REQ-008 busy  output  1  high whenever state is not IDLE.
REQ-009 wb_we  output  1  register-file write enable, one-cycle pulse.
REQ-010 wb_addr  output  3  register-file write address, valid while wb_we high.
REQ-011 wb_data  output  8  register-file write data, valid while wb_we high.
REQ-012 zf  output  1  zero flag of last written result.
REQ-013 cf  output  1  carry/borrow flag of last written result.

Function
REQ-014 The FSM SHALL have states IDLE, MUL, WB; all outputs SHALL be registered.
REQ-015 In IDLE with start=1 at edge k, op/a/b/dst SHALL be latched; later input changes SHALL not affect the result.
REQ-016 Non-MUL ops SHALL go IDLE->WB at edge k; wb_we=1 for exactly the cycle between edges k and k+1; IDLE at edge k+1.
REQ-017 MUL SHALL go IDLE->MUL at edge k, run 8 shift-add iterations (3-bit counter 0..7, one per cycle), enter WB at edge k+8, return to IDLE at edge k+9.
REQ-018 start SHALL be ignored in MUL and WB; no queuing; a new start is accepted at the first edge in IDLE.
REQ-019 ADD/SUB/SHL SHALL be modulo 256; MUL SHALL compute full 16-bit product internally and write the low byte.
REQ-020 cf SHALL be: ADD carry-out; SUB 1 iff a<b unsigned; SHL original a[7]; MUL 1 iff product[15:8]!=0; AND/OR/XOR/MOVB 0.
REQ-021 zf SHALL be 1 iff written byte is 0x00.
REQ-022 zf/cf SHALL update only on entry to WB and hold otherwise.
REQ-023 wb_addr/wb_data SHALL hold their last values when wb_we=0.
REQ-024 dst=7 SHALL be written normally; the consumer decides r7 handling.

Reset
REQ-025 reset=1 SHALL immediately force state IDLE, busy=0, wb_we=0, wb_addr=0, wb_data=0x00, zf=0, cf=0, MUL counter/accumulator=0.
REQ-026 reset mid-MUL or mid-WB SHALL abort without any write pulse; first start after reset deassertion SHALL be accepted normally.

Configuration
REQ-027 Macro EXEC_MUL_EN: defined -> MUL state and multiplier datapath present, REQ-017 applies.
REQ-028 EXEC_MUL_EN undefined -> no MUL state or multiplier logic; op 110 SHALL be accepted as a single-cycle op with no write (wb_we stays 0, flags unchanged), busy high for one cycle.

Verification
REQ-029 ADD a=0xF0 b=0x20 dst=3 -> one cycle later wb_we=1, wb_addr=3, wb_data=0x10, cf=1, zf=0.
REQ-030 SUB a=0x05 b=0x05 dst=1 -> wb_data=0x00, zf=1, cf=0; SUB a=0x03 b=0x04 -> wb_data=0xFF, cf=1.
REQ-031 MUL a=0x12 b=0x34 dst=5 (EXEC_MUL_EN) -> busy 9 cycles, wb_we only in 9th, wb_data=0xA8, cf=1; start pulses during busy ignored.
REQ-032 MUL started, reset asserted in 4th MUL cycle -> outputs zero immediately, no wb_we; subsequent XOR a=0xAA b=0xAA -> wb_data=0x00, zf=1.
REQ-033 Back-to-back: start held high with SHL a=0x81 -> writes 0x02 cf=1 every 2 cycles; without EXEC_MUL_EN op 110 -> no wb_we, flags unchanged.
